imem_port_arbiter: RTL and testbench

- Shares the single-port instruction memory between the instruction fetch stage and a program loader/debug port.
- Runs a request/grant handshake on each side and holds at most one memory transaction outstanding.
- Returns read data after a fixed memory latency, and drops fetch responses killed by a PC redirect (flush).
- fetch_gnt gates the PC register enable: the PC advances only on a granted fetch.

---
 rtl/imem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_imem_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - single-port instruction memory arbiter for fetch and loader ports
// Optional performance counters are built when IMEM_ARB_PERF_EN is defined.
module imem_port_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int MEM_LAT   = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_fetch_req,
  input  logic [31:0]       i_fetch_addr,
  input  logic              i_fetch_flush,
  output logic              o_fetch_gnt,
  output logic              o_fetch_rvalid,
  output logic [31:0]       o_fetch_rdata,
  input  logic              i_ld_req,
  input  logic              i_ld_we,
  input  logic [31:0]       i_ld_addr,
  input  logic [31:0]       i_ld_wdata,
  output logic              o_ld_gnt,
  output logic              o_ld_rvalid,
  output logic [31:0]       o_ld_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
`ifdef IMEM_ARB_PERF_EN
  input  logic [31:0]       i_mem_rdata,
  output logic [31:0]       o_perf_fetch_wait,
  output logic [15:0]       o_perf_flush_drop
`else
  input  logic [31:0]       i_mem_rdata
`endif
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [2:0] LAT_M1    = 3'(MEM_LAT - 1);
  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_streak, w_streak_nxt;
  logic        r_owner_ld, w_owner_ld_nxt;
  logic        r_owner_we, w_owner_we_nxt;
  logic        r_kill, w_kill_nxt;
  logic [31:0] r_fetch_rdata, r_ld_rdata;

  logic w_slot_free, w_resp, w_ld_win, w_fe_win, w_grant;
  logic w_fe_rvalid, w_ld_rvalid;
  logic w_unused;

  // Combinational outputs are gated by rst_n so everything reads 0 while in reset.
  assign w_resp      = rst_n && (r_state == S_BUSY) && (r_cnt == 3'd0);
  assign w_slot_free = rst_n && ((r_state == S_IDLE) || (r_cnt == 3'd0));
  assign w_ld_win    = w_slot_free && i_ld_req && (!i_fetch_req || (r_streak >= BURST_LIM));
  assign w_fe_win    = w_slot_free && i_fetch_req && !w_ld_win;
  assign w_grant     = w_fe_win || w_ld_win;

  // A flush arriving in the response cycle itself still suppresses that response.
  assign w_fe_rvalid = w_resp && !r_owner_ld && !r_kill && !i_fetch_flush;
  assign w_ld_rvalid = w_resp && r_owner_ld && !r_owner_we;

  assign o_fetch_gnt    = w_fe_win;
  assign o_ld_gnt       = w_ld_win;
  assign o_fetch_rvalid = w_fe_rvalid;
  assign o_ld_rvalid    = w_ld_rvalid;
  assign o_fetch_rdata  = w_fe_rvalid ? i_mem_rdata : r_fetch_rdata;
  assign o_ld_rdata     = w_ld_rvalid ? i_mem_rdata : r_ld_rdata;

  assign o_mem_en    = w_grant;
  assign o_mem_we    = w_ld_win && i_ld_we;
  assign o_mem_addr  = w_ld_win ? i_ld_addr[ADDR_W+1:2] :
                       w_fe_win ? i_fetch_addr[ADDR_W+1:2] : '0;
  assign o_mem_wdata = w_ld_win ? i_ld_wdata : '0;

  assign w_unused = ^{i_fetch_addr[31:ADDR_W+2], i_fetch_addr[1:0],
                      i_ld_addr[31:ADDR_W+2], i_ld_addr[1:0]};

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_owner_ld_nxt = r_owner_ld;
    w_owner_we_nxt = r_owner_we;
    w_kill_nxt     = r_kill;
    w_streak_nxt   = r_streak;

    if (w_grant) begin
      w_state_nxt    = S_BUSY;
      w_cnt_nxt      = LAT_M1;
      w_owner_ld_nxt = w_ld_win;
      w_owner_we_nxt = w_ld_win && i_ld_we;
      w_kill_nxt     = 1'b0;
    end else if (r_state == S_BUSY) begin
      if (r_cnt != 3'd0) begin
        w_cnt_nxt = r_cnt - 3'd1;
        if (!r_owner_ld && i_fetch_flush) begin
          w_kill_nxt = 1'b1;
        end
      end else begin
        w_state_nxt = S_IDLE;
        w_kill_nxt  = 1'b0;
      end
    end

    if (!i_ld_req || w_ld_win) begin
      w_streak_nxt = 4'd0;
    end else if (w_fe_win && (r_streak != 4'hF)) begin
      w_streak_nxt = r_streak + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 3'd0;
      r_streak      <= 4'd0;
      r_owner_ld    <= 1'b0;
      r_owner_we    <= 1'b0;
      r_kill        <= 1'b0;
      r_fetch_rdata <= 32'd0;
      r_ld_rdata    <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_streak   <= w_streak_nxt;
      r_owner_ld <= w_owner_ld_nxt;
      r_owner_we <= w_owner_we_nxt;
      r_kill     <= w_kill_nxt;
      if (w_fe_rvalid) begin
        r_fetch_rdata <= i_mem_rdata;
      end
      if (w_ld_rvalid) begin
        r_ld_rdata <= i_mem_rdata;
      end
    end
  end

`ifdef IMEM_ARB_PERF_EN
  logic        w_fe_drop;
  logic [31:0] r_perf_fetch_wait;
  logic [15:0] r_perf_flush_drop;

  assign w_fe_drop = w_resp && !r_owner_ld && (r_kill || i_fetch_flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch_wait <= 32'd0;
      r_perf_flush_drop <= 16'd0;
    end else begin
      if (i_fetch_req && !w_fe_win) begin
        r_perf_fetch_wait <= r_perf_fetch_wait + 32'd1;
      end
      if (w_fe_drop && (r_perf_flush_drop != 16'hFFFF)) begin
        r_perf_flush_drop <= r_perf_flush_drop + 16'd1;
      end
    end
  end

  assign o_perf_fetch_wait = r_perf_fetch_wait;
  assign o_perf_flush_drop = r_perf_flush_drop;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - directed self-checking bench for imem_port_arbiter
// Three instances (MEM_LAT 1/2/3) share the stimulus; each scenario checks one of them.
module tb_imem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        f_req, f_flush, l_req, l_we;
  logic [31:0] f_addr, l_addr, l_wdata;

  logic        fg1, frv1, lg1, lrv1, men1, mwe1;
  logic [31:0] frd1, lrd1, mwd1, mrd1;
  logic [11:0] ma1;
  logic        fg2, frv2, lg2, lrv2, men2, mwe2;
  logic [31:0] frd2, lrd2, mwd2, mrd2;
  logic [11:0] ma2;
  logic        fg3, frv3, lg3, lrv3, men3, mwe3;
  logic [31:0] frd3, lrd3, mwd3, mrd3;
  logic [11:0] ma3;

  int n_cmp = 0;
  int n_fail = 0;

  imem_port_arbiter #(.ADDR_W(12), .MEM_LAT(1), .MAX_BURST(4)) u1 (
    .clk(clk), .rst_n(rst_n),
    .i_fetch_req(f_req), .i_fetch_addr(f_addr), .i_fetch_flush(f_flush),
    .o_fetch_gnt(fg1), .o_fetch_rvalid(frv1), .o_fetch_rdata(frd1),
    .i_ld_req(l_req), .i_ld_we(l_we), .i_ld_addr(l_addr), .i_ld_wdata(l_wdata),
    .o_ld_gnt(lg1), .o_ld_rvalid(lrv1), .o_ld_rdata(lrd1),
    .o_mem_en(men1), .o_mem_we(mwe1), .o_mem_addr(ma1), .o_mem_wdata(mwd1),
    .i_mem_rdata(mrd1));

  imem_port_arbiter #(.ADDR_W(12), .MEM_LAT(2), .MAX_BURST(4)) u2 (
    .clk(clk), .rst_n(rst_n),
    .i_fetch_req(f_req), .i_fetch_addr(f_addr), .i_fetch_flush(f_flush),
    .o_fetch_gnt(fg2), .o_fetch_rvalid(frv2), .o_fetch_rdata(frd2),
    .i_ld_req(l_req), .i_ld_we(l_we), .i_ld_addr(l_addr), .i_ld_wdata(l_wdata),
    .o_ld_gnt(lg2), .o_ld_rvalid(lrv2), .o_ld_rdata(lrd2),
    .o_mem_en(men2), .o_mem_we(mwe2), .o_mem_addr(ma2), .o_mem_wdata(mwd2),
    .i_mem_rdata(mrd2));

  imem_port_arbiter #(.ADDR_W(12), .MEM_LAT(3), .MAX_BURST(4)) u3 (
    .clk(clk), .rst_n(rst_n),
    .i_fetch_req(f_req), .i_fetch_addr(f_addr), .i_fetch_flush(f_flush),
    .o_fetch_gnt(fg3), .o_fetch_rvalid(frv3), .o_fetch_rdata(frd3),
    .i_ld_req(l_req), .i_ld_we(l_we), .i_ld_addr(l_addr), .i_ld_wdata(l_wdata),
    .o_ld_gnt(lg3), .o_ld_rvalid(lrv3), .o_ld_rdata(lrd3),
    .o_mem_en(men3), .o_mem_we(mwe3), .o_mem_addr(ma3), .o_mem_wdata(mwd3),
    .i_mem_rdata(mrd3));

  // Memory model: word i preloaded with A000_0000+i; only u1 writes.
  logic [31:0] mem [0:4095];
  logic [31:0] rd1, p2a, p2b, p3a, p3b, p3c;
  initial for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 + 32'(i);
  always @(posedge clk) begin
    if (men1 && mwe1) mem[ma1] <= mwd1;
    rd1 <= mem[ma1];
    p2a <= mem[ma2]; p2b <= p2a;
    p3a <= mem[ma3]; p3b <= p3a; p3c <= p3b;
  end
  assign mrd1 = rd1;
  assign mrd2 = p2b;
  assign mrd3 = p3c;

  task automatic drive(input logic req, input logic [31:0] addr, input logic flush);
    @(negedge clk);
    f_req = req; f_addr = addr; f_flush = flush;
    #1;
  endtask

  task automatic idle(input int n);
    f_req = 1'b0; f_flush = 1'b0; l_req = 1'b0; l_we = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    f_req = 1'b1; f_addr = 32'h10; f_flush = 1'b0;
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h20; l_wdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({fg1, lg1, men1, mwe1} !== 4'b0) begin n_fail++; $display("FAIL reset_gnt_en got %b want 0000", {fg1, lg1, men1, mwe1}); end
    n_cmp++; if ({frv1, lrv1} !== 2'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 00", {frv1, lrv1}); end
    n_cmp++; if (ma1 !== 12'd0 || mwd1 !== 32'd0) begin n_fail++; $display("FAIL reset_mem_bus got %h/%h want 0/0", ma1, mwd1); end
    n_cmp++; if (frd1 !== 32'd0 || lrd1 !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h/%h want 0/0", frd1, lrd1); end
    n_cmp++; if ({fg2, fg3, men2, men3} !== 4'b0) begin n_fail++; $display("FAIL reset_other_inst got %b want 0000", {fg2, fg3, men2, men3}); end
    @(negedge clk);
    idle(0);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_fetch_stream();
    logic [31:0] exp_rd;
    for (int i = 0; i < 5; i++) begin
      drive(i < 3, 32'(i * 4), 1'b0);
      n_cmp++; if (fg1 !== 1'(i < 3)) begin n_fail++; $display("FAIL stream_gnt c%0d got %b want %b", i, fg1, i < 3); end
      if (i < 3) begin
        n_cmp++; if (ma1 !== 12'(i)) begin n_fail++; $display("FAIL stream_addr c%0d got %h want %h", i, ma1, i); end
      end
      n_cmp++; if (frv1 !== 1'(i >= 1 && i <= 3)) begin n_fail++; $display("FAIL stream_rvalid c%0d got %b want %b", i, frv1, i >= 1 && i <= 3); end
      if (i >= 1) begin
        exp_rd = 32'hA000_0000 + 32'((i <= 3) ? i - 1 : 2);
        n_cmp++; if (frd1 !== exp_rd) begin n_fail++; $display("FAIL stream_rdata c%0d got %h want %h", i, frd1, exp_rd); end
      end
    end
    idle(3);
  endtask

  task automatic test_latency3();
    logic [1:0] exp_rv;
    for (int i = 0; i < 8; i++) begin
      drive(i <= 3, (i == 0) ? 32'h100 : 32'h104, 1'b0);
      n_cmp++; if (fg3 !== 1'(i == 0 || i == 3) || men3 !== 1'(i == 0 || i == 3)) begin
        n_fail++; $display("FAIL lat3_gnt c%0d got %b%b want %b", i, fg3, men3, i == 0 || i == 3); end
      if (i == 0 || i == 3) begin
        n_cmp++; if (ma3 !== ((i == 0) ? 12'h040 : 12'h041)) begin n_fail++; $display("FAIL lat3_addr c%0d got %h", i, ma3); end
      end
      exp_rv = {1'b0, 1'(i == 3 || i == 6)};
      n_cmp++; if ({1'b0, frv3} !== exp_rv) begin n_fail++; $display("FAIL lat3_rvalid c%0d got %b want %b", i, frv3, exp_rv[0]); end
      if (i == 3 || i == 6) begin
        n_cmp++; if (frd3 !== ((i == 3) ? 32'hA000_0040 : 32'hA000_0041)) begin n_fail++; $display("FAIL lat3_rdata c%0d got %h", i, frd3); end
      end
    end
    idle(4);
  endtask

  task automatic test_burst();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      f_req = 1'b1; f_addr = 32'h0; f_flush = 1'b0;
      l_req = 1'b1; l_we = 1'b0; l_addr = 32'h10;
      #1;
      n_cmp++; if (fg1 !== 1'(i % 5 != 4)) begin n_fail++; $display("FAIL burst_fgnt c%0d got %b want %b", i, fg1, i % 5 != 4); end
      n_cmp++; if (lg1 !== 1'(i % 5 == 4)) begin n_fail++; $display("FAIL burst_lgnt c%0d got %b want %b", i, lg1, i % 5 == 4); end
      n_cmp++; if (frv1 !== 1'(i > 0 && (i - 1) % 5 != 4)) begin n_fail++; $display("FAIL burst_frv c%0d got %b", i, frv1); end
      n_cmp++; if (lrv1 !== 1'(i == 5)) begin n_fail++; $display("FAIL burst_lrv c%0d got %b want %b", i, lrv1, i == 5); end
      if (i == 5) begin
        n_cmp++; if (lrd1 !== 32'hA000_0004) begin n_fail++; $display("FAIL burst_lrdata got %h want a0000004", lrd1); end
      end
    end
    idle(3);
  endtask

  task automatic test_loader_rw();
    @(negedge clk);
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h20; l_wdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (lg1 !== 1'b1 || mwe1 !== 1'b1 || men1 !== 1'b1) begin n_fail++; $display("FAIL ldw_gnt got g%b we%b en%b want 111", lg1, mwe1, men1); end
    n_cmp++; if (ma1 !== 12'h008 || mwd1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ldw_bus got %h/%h want 008/deadbeef", ma1, mwd1); end
    @(negedge clk);
    l_we = 1'b0;
    #1;
    n_cmp++; if (lg1 !== 1'b1 || mwe1 !== 1'b0 || ma1 !== 12'h008) begin n_fail++; $display("FAIL ldr_gnt got g%b we%b a%h", lg1, mwe1, ma1); end
    n_cmp++; if (lrv1 !== 1'b0) begin n_fail++; $display("FAIL ldw_no_rvalid got %b want 0", lrv1); end
    n_cmp++; if (lrd1 !== 32'hA000_0004) begin n_fail++; $display("FAIL ld_rdata_hold got %h want a0000004", lrd1); end
    @(negedge clk);
    l_req = 1'b0;
    #1;
    n_cmp++; if (lrv1 !== 1'b1 || lrd1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ldr_resp got %b/%h want 1/deadbeef", lrv1, lrd1); end
    n_cmp++; if (frv1 !== 1'b0) begin n_fail++; $display("FAIL ldr_no_fetch_rv got %b want 0", frv1); end
    idle(3);
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h40, 1'b0);
    n_cmp++; if (fg2 !== 1'b1 || ma2 !== 12'h010) begin n_fail++; $display("FAIL flush_g0 got %b/%h want 1/010", fg2, ma2); end
    drive(1'b1, 32'h200, 1'b1);
    n_cmp++; if (fg2 !== 1'b0) begin n_fail++; $display("FAIL flush_busy_gnt got %b want 0", fg2); end
    drive(1'b1, 32'h200, 1'b0);
    n_cmp++; if (fg2 !== 1'b1 || ma2 !== 12'h080) begin n_fail++; $display("FAIL flush_redirect got %b/%h want 1/080", fg2, ma2); end
    n_cmp++; if (frv2 !== 1'b0) begin n_fail++; $display("FAIL flush_killed got %b want 0", frv2); end
    drive(1'b0, 32'h0, 1'b0);
    n_cmp++; if (frv2 !== 1'b0) begin n_fail++; $display("FAIL flush_gap got %b want 0", frv2); end
    drive(1'b0, 32'h0, 1'b0);
    n_cmp++; if (frv2 !== 1'b1 || frd2 !== 32'hA000_0080) begin n_fail++; $display("FAIL flush_target got %b/%h want 1/a0000080", frv2, frd2); end
    drive(1'b1, 32'h44, 1'b0);
    n_cmp++; if (frv2 !== 1'b0 || fg2 !== 1'b1) begin n_fail++; $display("FAIL flush_g2 got rv%b g%b want 0/1", frv2, fg2); end
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    n_cmp++; if (frv2 !== 1'b0) begin n_fail++; $display("FAIL flush_resp_cycle got %b want 0", frv2); end
    n_cmp++; if (frd2 !== 32'hA000_0080) begin n_fail++; $display("FAIL flush_rdata_hold got %h want a0000080", frd2); end
    idle(2);
    drive(1'b1, 32'h48, 1'b1);
    n_cmp++; if (fg1 !== 1'b1) begin n_fail++; $display("FAIL flush_same_cycle_gnt got %b want 1", fg1); end
    drive(1'b0, 32'h0, 1'b0);
    n_cmp++; if (frv1 !== 1'b1 || frd1 !== 32'hA000_0012) begin n_fail++; $display("FAIL flush_same_cycle_rv got %b/%h want 1/a0000012", frv1, frd1); end
    idle(4);
  endtask

  task automatic test_reset_busy();
    drive(1'b1, 32'h100, 1'b0);
    n_cmp++; if (fg3 !== 1'b1) begin n_fail++; $display("FAIL rstb_gnt got %b want 1", fg3); end
    @(negedge clk);
    rst_n = 1'b0; f_req = 1'b1; f_addr = 32'h104;
    #1;
    n_cmp++; if ({fg3, men3, mwe3, frv3, lrv3} !== 5'b0) begin n_fail++; $display("FAIL rstb_ctrl got %b want 00000", {fg3, men3, mwe3, frv3, lrv3}); end
    n_cmp++; if (frd3 !== 32'd0 || ma3 !== 12'd0) begin n_fail++; $display("FAIL rstb_data got %h/%h want 0/0", frd3, ma3); end
    @(negedge clk);
    rst_n = 1'b1; f_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (frv3 !== 1'b0) begin n_fail++; $display("FAIL rstb_no_rv c%0d got %b want 0", i, frv3); end
      @(negedge clk);
    end
    f_req = 1'b1; f_addr = 32'h8;
    #1;
    n_cmp++; if (fg3 !== 1'b1 || ma3 !== 12'h002) begin n_fail++; $display("FAIL rstb_first_gnt got %b/%h want 1/002", fg3, ma3); end
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    n_cmp++; if (frv3 !== 1'b1 || frd3 !== 32'hA000_0002) begin n_fail++; $display("FAIL rstb_first_resp got %b/%h want 1/a0000002", frv3, frd3); end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_fetch_stream();
    test_latency3();
    test_burst();
    test_loader_rw();
    test_flush();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
